// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned NS_PER_SEC = 1_000_000_000;

  // Integer division at each step keeps tx and rx timing bit-identical.
  function automatic int unsigned cycles_per_bit(input int unsigned bit_rate,
                                                 input int unsigned clk_hz);
    return (NS_PER_SEC / bit_rate) / (NS_PER_SEC / clk_hz);
  endfunction

  function automatic int unsigned count_reg_len(input int unsigned cpb);
    return 32'(1 + $clog2(cpb));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; ticks on the last cycle of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 5208,
  parameter int unsigned COUNT_REG_LEN  = count_reg_len(CYCLES_PER_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_bit_tick_c
);

  logic [COUNT_REG_LEN-1:0] r_count;

  assign o_bit_tick_c = (r_count == COUNT_REG_LEN'(CYCLES_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear || o_bit_tick_c) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data LSB first, STOP_BITS stop bits,
// with an optional BREAK frame that holds the line low through the data field.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_tx_en,
  input  logic                    uart_tx_valid,
  output logic                    uart_tx_ready,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_break,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
  localparam int unsigned COUNT_REG_LEN  = count_reg_len(CYCLES_PER_BIT);
  localparam int unsigned BIT_CNT_W      = 4;

  uart_state_t             r_state, w_state_nxt;
  logic [BIT_CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_nxt;
  logic                    r_break, w_break_nxt;
  logic                    r_txd, w_txd_nxt;
  logic                    w_handshake;
  logic                    w_bit_tick;
  logic                    w_timer_clr;

  assign uart_tx_ready = (r_state == IDLE) && uart_tx_en && !reset;
  assign uart_tx_busy  = (r_state != IDLE);
  assign uart_txd      = r_txd;
  assign w_handshake   = uart_tx_valid && uart_tx_ready;
  assign w_timer_clr   = (r_state == IDLE);

  uart_bit_timer #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT),
    .COUNT_REG_LEN  (COUNT_REG_LEN)
  ) u_bit_timer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_timer_clr),
    .o_bit_tick_c (w_bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_break   <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_break   <= w_break_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_break_nxt   = r_break;
    w_txd_nxt     = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_nxt   = START;
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = uart_tx_break ? '0 : uart_tx_data;
          w_break_nxt   = uart_tx_break;
        end
      end
      START: begin
        if (w_bit_tick) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_CNT_W'(PAYLOAD_BITS - 1)) begin
            w_state_nxt   = STOP;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is registered from the upcoming state so each bit starts on the edge.
    unique case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0] & ~w_break_nxt;
      default: w_txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; frames are captured per cycle
// and checked bit-by-bit against hand-computed line levels.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       uart_tx_en;
  logic       uart_tx_valid;
  logic       uart_tx_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_break;
  logic       uart_tx_busy;
  logic       uart_txd;

  int n_vec;
  int n_err;

  logic line_s  [256];
  logic ready_s [256];
  logic busy_s  [256];

  uart_tx #(
    .BIT_RATE     (100_000),
    .CLK_HZ       (1_000_000),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_break (uart_tx_break),
    .uart_tx_busy  (uart_tx_busy),
    .uart_txd      (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles of outputs starting at index base, advancing one clock per sample.
  task automatic capture(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      line_s[base + k]  = uart_txd;
      ready_s[base + k] = uart_tx_ready;
      busy_s[base + k]  = uart_tx_busy;
      tick();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic brk);
    uart_tx_data  = d;
    uart_tx_break = brk;
    uart_tx_valid = 1'b1;
    chk("hs_ready", 32'(uart_tx_ready), 32'd1);
    tick();
    uart_tx_valid = 1'b0;
    uart_tx_break = 1'b0;
    chk("first_low", 32'(uart_txd), 32'd0);
  endtask

  // Every one of the 10 cycles of each of the 10 bits must hold the expected level.
  task automatic check_frame(input string tag, input int base, input logic [7:0] d);
    logic       e;
    logic [9:0] obs;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = d[b-1];
      for (int c = 0; c < 10; c++) obs[c] = line_s[base + 10*b + c];
      chk($sformatf("%s_bit%0d", tag, b), 32'(obs), e ? 32'h3FF : 32'h0);
    end
  endtask

  initial begin
    int lows;
    int highs;
    logic all_busy;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    uart_tx_en = 1'b1;
    uart_tx_valid = 1'b0;
    uart_tx_data = 8'h00;
    uart_tx_break = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_txd", 32'(uart_txd), 32'd1);
      chk("rst_busy", 32'(uart_tx_busy), 32'd0);
      chk("rst_ready", 32'(uart_tx_ready), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(uart_tx_ready), 32'd1);
    chk("rel_txd", 32'(uart_txd), 32'd1);

    // Single 0xA5 frame
    send(8'hA5, 1'b0);
    capture(0, 100);
    check_frame("a5", 0, 8'hA5);
    chk("a5_low_end", 32'(line_s[9]), 32'd0);
    chk("a5_bit0_begin", 32'(line_s[10]), 32'd1);
    all_busy = 1'b1;
    for (int k = 0; k < 100; k++) all_busy &= busy_s[k] & ~ready_s[k];
    chk("a5_busy_frame", 32'(all_busy), 32'd1);
    chk("a5_ready_back", 32'(uart_tx_ready), 32'd1);
    chk("a5_busy_end", 32'(uart_tx_busy), 32'd0);

    // Back-to-back 0x00 then 0xFF with valid held
    uart_tx_data  = 8'h00;
    uart_tx_valid = 1'b1;
    tick();
    uart_tx_data = 8'hFF;
    capture(0, 201);
    uart_tx_valid = 1'b0;
    check_frame("b2b0", 0, 8'h00);
    check_frame("b2b1", 101, 8'hFF);
    chk("b2b_gap_high", 32'(line_s[100]), 32'd1);
    chk("b2b_gap_ready", 32'(ready_s[100]), 32'd1);
    chk("b2b_second_start", 32'(line_s[101]), 32'd0);

    // BREAK frame with data 0x5A
    tick();
    send(8'h5A, 1'b1);
    capture(0, 100);
    lows = 0;
    highs = 0;
    for (int k = 0; k < 90; k++) lows += (line_s[k] == 1'b0) ? 1 : 0;
    for (int k = 90; k < 100; k++) highs += (line_s[k] == 1'b1) ? 1 : 0;
    chk("brk_low_cycles", 32'(lows), 32'd90);
    chk("brk_stop_cycles", 32'(highs), 32'd10);
    chk("brk_idle_after", 32'(uart_txd), 32'd1);

    // Enable dropped at cycle 30 of a frame
    send(8'h81, 1'b0);
    capture(0, 30);
    uart_tx_en = 1'b0;
    capture(30, 70);
    check_frame("en_off", 0, 8'h81);
    chk("en_off_ready", 32'(uart_tx_ready), 32'd0);
    chk("en_off_busy", 32'(uart_tx_busy), 32'd0);
    uart_tx_valid = 1'b1;
    uart_tx_data  = 8'h42;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_off_hold", 32'({uart_tx_busy, uart_tx_ready, uart_txd}), 32'b001);
    end
    uart_tx_en = 1'b1;
    #1;
    send(8'h42, 1'b0);
    capture(0, 100);
    check_frame("en_on", 0, 8'h42);

    // Reset at cycle 45 of a frame, then a fresh 0x3C frame
    send(8'hC3, 1'b0);
    capture(0, 45);
    reset = 1'b1;
    tick();
    chk("mid_rst_txd", 32'(uart_txd), 32'd1);
    chk("mid_rst_busy", 32'(uart_tx_busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(uart_tx_ready), 32'd1);
    send(8'h3C, 1'b0);
    capture(0, 100);
    check_frame("post_rst", 0, 8'h3C);
    chk("post_rst_ready", 32'(uart_tx_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serializes one PAYLOAD_BITS word per frame onto uart_txd as start bit (low), data LSB first, then STOP_BITS stop bits (high).
- Counterpart to the UART receiver; shares BIT_RATE/CLK_HZ/PAYLOAD_BITS/STOP_BITS semantics so a tx→rx loopback is frame-compatible.
- Sits between the fabric-side valid/ready producer and the TX pin; it can also emit a BREAK frame that the receiver flags as break.

Parameters:
- BIT_RATE, 9600: line bit rate, bits/s.
- CLK_HZ, 50_000_000: clk frequency, Hz.
- PAYLOAD_BITS, 8: data bits per frame (1..15).
- STOP_BITS, 1: stop bits per frame (1 or 2).
- Derived constant: CYCLES_PER_BIT = (1e9/BIT_RATE)/(1e9/CLK_HZ), using integer division at each step. Default value is 5208.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_tx_en  in  1  transmit enable; when low, no new frame is accepted.
- uart_tx_valid  in  1  producer has a word (or break request) available.
- uart_tx_ready  out  1  block can accept a word this cycle.
- uart_tx_data  in  PAYLOAD_BITS  word to send; sampled on handshake.
- uart_tx_break  in  1  on handshake, send a BREAK frame instead of data.
- uart_tx_busy  out  1  a frame is in progress (any state except IDLE).
- uart_txd  out  1  serial line, registered, idles high.

Behaviour:
- Reset (clk edge with reset=1) → state IDLE, uart_txd=1, uart_tx_ready=0 in the reset cycle, uart_tx_busy=0, counters=0, shift register=0. Reset mid-frame aborts the frame; uart_txd is high the cycle after.
- uart_tx_ready = (state==IDLE) && uart_tx_en && !reset. It is combinational from the state register.
- Handshake: accept on a clk edge where valid && ready. Latch uart_tx_data into the shift register and latch uart_tx_break. Data/break are don't-care when there is no handshake.
- FSM states:
  - IDLE → START on handshake.
  - START → DATA after CYCLES_PER_BIT cycles.
  - DATA → STOP after PAYLOAD_BITS bit periods.
  - STOP → IDLE after STOP_BITS bit periods.
- Line levels per state:
  - START: uart_txd=0.
  - DATA: uart_txd = shift register bit 0; the register shifts right once per bit period.
  - STOP: uart_txd=1.
  - IDLE: uart_txd=1.
- Latency: the first low cycle of uart_txd is the cycle after the handshake edge. Each bit is held exactly CYCLES_PER_BIT cycles.
- Cycle counter runs 0..CYCLES_PER_BIT-1, then wraps to 0 and advances the bit. Bit counter counts 0..PAYLOAD_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
- Frame length: (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles of non-idle line. ready reasserts in the cycle after the last stop-bit cycle.
- Back-to-back frames: if valid is held, the next start bit follows after exactly one idle-high cycle (the IDLE cycle in which the handshake occurs).
- BREAK frame: uart_txd=0 for the start bit plus all PAYLOAD_BITS periods (shift register forced to 0), then normal stop bits. Timing is identical to a data frame.
- uart_tx_en low mid-frame: the current frame completes normally; no new acceptance until uart_tx_en is high again.
- uart_tx_valid dropping mid-frame has no effect.
- uart_tx_busy = (state != IDLE).

Decomposition:
- Package uart_pkg holds:
  - FSM state typedef (IDLE/START/DATA/STOP, 2 bits).
  - Function computing CYCLES_PER_BIT from BIT_RATE and CLK_HZ, shared with the receiver.
  - COUNT_REG_LEN = 1+$clog2(CYCLES_PER_BIT).
- One natural sub-module: uart_bit_timer, a cycle counter with clear input and bit_tick output (tick on count==CYCLES_PER_BIT-1). It is reusable by the receiver.

Test Plan (sim params CLK_HZ=1_000_000, BIT_RATE=100_000 → CYCLES_PER_BIT=10):
1. Reset held 3 cycles, then released with uart_tx_en=1 → uart_txd=1 and busy=0 throughout reset; ready=1 on the first cycle after release.
2. Send 0xA5 (valid pulsed 1 cycle) → uart_txd sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1. The line is low for exactly 10 cycles starting one cycle after the handshake. ready returns 100 cycles after the first low cycle.
3. valid held with 0x00 then 0xFF back-to-back → second start bit begins exactly 1 high cycle after the first frame's stop bit ends. A loopback uart_rx reports 0x00 then 0xFF with no break flag.
4. uart_tx_break=1 with data=0x5A → line low 90 cycles, then high 10 cycles. A loopback receiver asserts uart_rx_break.
5. Deassert uart_tx_en at cycle 30 of a frame → frame completes to stop bit; ready stays 0 until uart_tx_en returns high.
6. Assert reset at cycle 45 of a frame → uart_txd=1 and busy=0 on the next cycle. After release, a fresh 0x3C frame is transmitted correctly.
